// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared definitions for the ALU command controller: command bytes, FSM encodings,
// ALU function codes and the flag-byte layout.
package alu_cmd_ctrl_pkg;

    localparam logic [7:0] CMD_OPER  = 8'hCC;
    localparam logic [7:0] CMD_NOPER = 8'hDD;

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_LO,
        S_A_HI,
        S_B_LO,
        S_B_HI,
        S_FUN,
        S_EXEC,
        S_WAIT,
        S_TX
    } ctrl_state_e;

    // Byte phases of the result transfer, owned by the serializer.
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LO,
        TX_HI,
        TX_FLG
    } tx_state_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'h0,
        ALU_SUB    = 4'h1,
        ALU_MUL    = 4'h2,
        ALU_DIV    = 4'h3,
        ALU_AND    = 4'h4,
        ALU_OR     = 4'h5,
        ALU_NAND   = 4'h6,
        ALU_NOR    = 4'h7,
        ALU_XOR    = 4'h8,
        ALU_XNOR   = 4'h9,
        ALU_CMP_EQ = 4'hA,
        ALU_CMP_GT = 4'hB,
        ALU_CMP_LT = 4'hC,
        ALU_SHR    = 4'hD,
        ALU_SHL    = 4'hE
    } alu_fun_e;

    typedef struct packed {
        logic arith;
        logic logical;
        logic cmp;
        logic shift;
    } alu_flags_t;

    function automatic logic [7:0] flag_byte(input alu_flags_t flags);
        return {4'b0000, flags};
    endfunction

endpackage

// File: rtl/alu_tx_serializer.sv
// Sends a latched ALU result to the UART TX path as low byte, high byte and, when
// ALU_FLAG_BYTE_EN is defined, a flag byte; pulses done after the last accept.
module alu_tx_serializer #(
    parameter int DATA_W = 8,
    parameter int OPER_W = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [OPER_W-1:0]               result,
`ifdef ALU_FLAG_BYTE_EN
    input  alu_cmd_ctrl_pkg::alu_flags_t    flags,
`endif
    input  logic                            tx_busy,
    output logic [DATA_W-1:0]               tx_p_data,
    output logic                            tx_d_vld,
    output logic                            done
);
    import alu_cmd_ctrl_pkg::*;

    tx_state_e state;
    logic      accept;

    assign accept = tx_d_vld && !tx_busy;

    // After every accept tx_d_vld drops for one cycle; the next byte is loaded in that gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= TX_IDLE;
            tx_p_data <= '0;
            tx_d_vld  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                TX_IDLE: begin
                    if (start) begin
                        tx_p_data <= result[DATA_W-1:0];
                        tx_d_vld  <= 1'b1;
                        state     <= TX_LO;
                    end
                end
                TX_LO: begin
                    if (accept) begin
                        tx_d_vld <= 1'b0;
                        state    <= TX_HI;
                    end
                end
                TX_HI: begin
                    if (!tx_d_vld) begin
                        tx_p_data <= result[OPER_W-1:DATA_W];
                        tx_d_vld  <= 1'b1;
                    end else if (!tx_busy) begin
                        tx_d_vld <= 1'b0;
`ifdef ALU_FLAG_BYTE_EN
                        state    <= TX_FLG;
`else
                        done     <= 1'b1;
                        state    <= TX_IDLE;
`endif
                    end
                end
`ifdef ALU_FLAG_BYTE_EN
                TX_FLG: begin
                    if (!tx_d_vld) begin
                        tx_p_data <= DATA_W'(flag_byte(flags));
                        tx_d_vld  <= 1'b1;
                    end else if (!tx_busy) begin
                        tx_d_vld <= 1'b0;
                        done     <= 1'b1;
                        state    <= TX_IDLE;
                    end
                end
`endif
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// ALU initiator: decodes RX command frames, fires ALU_EN, waits for the result and
// returns it over TX. Optional flag byte enabled by ALU_FLAG_BYTE_EN.
module alu_cmd_ctrl #(
    parameter int DATA_W   = 8,
    parameter int OPER_W   = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] RX_P_DATA,
    input  logic              RX_D_VLD,
    output logic [OPER_W-1:0] ALU_A,
    output logic [OPER_W-1:0] ALU_B,
    output logic [3:0]        ALU_FUN,
    output logic              ALU_EN,
    input  logic [OPER_W-1:0] ALU_OUT,
    input  logic              OUT_VALID,
    input  logic              Arith_Flag,
    input  logic              Logic_Flag,
    input  logic              CMP_Flag,
    input  logic              Shift_Flag,
    output logic [DATA_W-1:0] TX_P_DATA,
    output logic              TX_D_VLD,
    input  logic              TX_BUSY,
    output logic              ERR
);
    import alu_cmd_ctrl_pkg::*;

    localparam int CNT_W = $clog2(WAIT_MAX);
    // ERR lands WAIT_MAX cycles after ALU_EN; OUT_VALID on the final WAIT cycle still wins.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 2);

    ctrl_state_e       state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [OPER_W-1:0] res_q;
    logic              tx_start;
    logic              tx_done;

`ifdef ALU_FLAG_BYTE_EN
    alu_flags_t flg_q;
`else
    logic unused_flags;
    assign unused_flags = ^{Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
`endif

    // NOTE: pulse outputs get a default of 0 at the top of the clocked branch and are
    // overridden below; every assignment here is non-blocking so all state updates together.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            ALU_A    <= '0;
            ALU_B    <= '0;
            ALU_FUN  <= '0;
            ALU_EN   <= 1'b0;
            ERR      <= 1'b0;
            tx_start <= 1'b0;
            wait_cnt <= '0;
            res_q    <= '0;
`ifdef ALU_FLAG_BYTE_EN
            flg_q    <= '0;
`endif
        end else begin
            ALU_EN   <= 1'b0;
            ERR      <= 1'b0;
            tx_start <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == DATA_W'(CMD_OPER))
                            state <= S_A_LO;
                        else if (RX_P_DATA == DATA_W'(CMD_NOPER))
                            state <= S_FUN;
                    end
                end
                S_A_LO: begin
                    if (RX_D_VLD) begin
                        ALU_A[DATA_W-1:0] <= RX_P_DATA;
                        state             <= S_A_HI;
                    end
                end
                S_A_HI: begin
                    if (RX_D_VLD) begin
                        ALU_A[OPER_W-1:DATA_W] <= RX_P_DATA;
                        state                  <= S_B_LO;
                    end
                end
                S_B_LO: begin
                    if (RX_D_VLD) begin
                        ALU_B[DATA_W-1:0] <= RX_P_DATA;
                        state             <= S_B_HI;
                    end
                end
                S_B_HI: begin
                    if (RX_D_VLD) begin
                        ALU_B[OPER_W-1:DATA_W] <= RX_P_DATA;
                        state                  <= S_FUN;
                    end
                end
                S_FUN: begin
                    if (RX_D_VLD) begin
                        ALU_FUN <= RX_P_DATA[3:0];
                        ALU_EN  <= 1'b1;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (OUT_VALID) begin
                        res_q    <= ALU_OUT;
`ifdef ALU_FLAG_BYTE_EN
                        flg_q    <= '{arith: Arith_Flag, logical: Logic_Flag,
                                      cmp: CMP_Flag, shift: Shift_Flag};
`endif
                        tx_start <= 1'b1;
                        state    <= S_TX;
                    end else if (wait_cnt == WAIT_LAST) begin
                        ERR   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_TX: begin
                    if (tx_done)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    alu_tx_serializer #(
        .DATA_W (DATA_W),
        .OPER_W (OPER_W)
    ) u_tx_serializer (
        .clk       (CLK),
        .rst_n     (RST),
        .start     (tx_start),
        .result    (res_q),
`ifdef ALU_FLAG_BYTE_EN
        .flags     (flg_q),
`endif
        .tx_busy   (TX_BUSY),
        .tx_p_data (TX_P_DATA),
        .tx_d_vld  (TX_D_VLD),
        .done      (tx_done)
    );

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl: frame-level model with expectation queues,
// an ALU stand-in responder, random TX backpressure and directed boundary cases.
`timescale 1ns/1ps
module tb_alu_cmd_ctrl;
    import alu_cmd_ctrl_pkg::*;

    localparam int DATA_W   = 8;
    localparam int OPER_W   = 16;
    localparam int WAIT_MAX = 15;
`ifdef ALU_FLAG_BYTE_EN
    localparam int TX_BYTES = 3;
`else
    localparam int TX_BYTES = 2;
`endif

    logic              CLK = 1'b0;
    logic              RST;
    logic [DATA_W-1:0] RX_P_DATA;
    logic              RX_D_VLD;
    logic [OPER_W-1:0] ALU_A, ALU_B;
    logic [3:0]        ALU_FUN;
    logic              ALU_EN;
    logic [OPER_W-1:0] ALU_OUT;
    logic              OUT_VALID;
    logic              Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
    logic [DATA_W-1:0] TX_P_DATA;
    logic              TX_D_VLD;
    logic              TX_BUSY;
    logic              ERR;

    always #5 CLK = ~CLK;

    alu_cmd_ctrl #(.DATA_W(DATA_W), .OPER_W(OPER_W), .WAIT_MAX(WAIT_MAX)) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY), .ERR(ERR)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fun;
    } exec_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    exec_t       exec_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  tx_log[$];
    int          err_expect = 0;
    int          en_count = 0;
    int          en_cyc = 0;
    logic [15:0] m_a = '0, m_b = '0;
    int          resp_delay = 0;
    logic [3:0]  resp_flags = '0;
    bit          force_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] alu_calc(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        case (f)
            ALU_ADD:    return a + b;
            ALU_SUB:    return a - b;
            ALU_MUL:    return a * b;
            ALU_DIV:    return (b == 0) ? 16'h0000 : a / b;
            ALU_AND:    return a & b;
            ALU_OR:     return a | b;
            ALU_NAND:   return ~(a & b);
            ALU_NOR:    return ~(a | b);
            ALU_XOR:    return a ^ b;
            ALU_XNOR:   return ~(a ^ b);
            ALU_CMP_EQ: return (a == b) ? 16'd1 : 16'd0;
            ALU_CMP_GT: return (a > b) ? 16'd1 : 16'd0;
            ALU_CMP_LT: return (a < b) ? 16'd1 : 16'd0;
            ALU_SHR:    return a >> 1;
            ALU_SHL:    return a << 1;
            default:    return 16'h0000;
        endcase
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // ALU stand-in: answers each ALU_EN after resp_delay cycles (0 = never answer).
    initial begin
        logic [15:0] res;
        OUT_VALID = 1'b0;
        ALU_OUT   = 16'hA5A5;
        {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} = 4'hF;
        forever begin
            @(negedge CLK);
            if (RST && ALU_EN && resp_delay > 0) begin
                res = alu_calc(ALU_A, ALU_B, ALU_FUN);
                repeat (resp_delay) @(posedge CLK);
                #1;
                OUT_VALID = 1'b1;
                ALU_OUT   = res;
                {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} = resp_flags;
                @(posedge CLK);
                #1;
                OUT_VALID = 1'b0;
                ALU_OUT   = 16'($urandom);
                {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} = 4'($urandom);
            end
        end
    end

    initial begin
        forever begin
            TX_BUSY = force_busy || ($urandom_range(0, 2) == 0);
            @(posedge CLK);
            #1;
        end
    end

    // Compare process: checks DUT outputs against the expectation queues every cycle.
    bit         prev_vld, prev_acc, prev_en, acc;
    logic [7:0] prev_data, exp_byte;
    exec_t      e_cur;

    always @(negedge CLK) begin
        if (!RST) begin
            prev_vld = 1'b0;
            prev_acc = 1'b0;
            prev_en  = 1'b0;
        end else begin
            if (ALU_EN) begin
                en_count++;
                en_cyc = cyc;
                check("alu_en_single_cycle", 64'(prev_en), 64'd0);
                check("alu_en_expected", 64'(exec_q.size() > 0), 64'd1);
                if (exec_q.size() > 0) begin
                    e_cur = exec_q.pop_front();
                    check("alu_a", 64'(ALU_A), 64'(e_cur.a));
                    check("alu_b", 64'(ALU_B), 64'(e_cur.b));
                    check("alu_fun", 64'(ALU_FUN), 64'(e_cur.fun));
                end
            end
            prev_en = ALU_EN;
            if (ERR) begin
                check("err_expected", 64'(err_expect > 0), 64'd1);
                if (err_expect > 0) err_expect--;
                check("err_latency", 64'(cyc - en_cyc), 64'(WAIT_MAX));
            end
            if (prev_vld && !prev_acc) begin
                check("tx_vld_hold", 64'(TX_D_VLD), 64'd1);
                check("tx_data_hold", 64'(TX_P_DATA), 64'(prev_data));
            end
            if (prev_acc)
                check("tx_vld_gap", 64'(TX_D_VLD), 64'd0);
            acc = TX_D_VLD && !TX_BUSY;
            if (acc) begin
                check("tx_expected", 64'(tx_q.size() > 0), 64'd1);
                if (tx_q.size() > 0) begin
                    exp_byte = tx_q.pop_front();
                    check("tx_byte", 64'(TX_P_DATA), 64'(exp_byte));
                end
                tx_log.push_back(TX_P_DATA);
            end
            prev_vld  = TX_D_VLD;
            prev_acc  = acc;
            prev_data = TX_P_DATA;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick(1);
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'($urandom);
        tick($urandom_range(0, 2));
    endtask

    task automatic rx_inject();
        int sel;
        sel = $urandom_range(0, 3);
        RX_D_VLD  = $urandom_range(0, 1) == 1;
        RX_P_DATA = (sel == 0) ? CMD_OPER : (sel == 1) ? CMD_NOPER : 8'($urandom);
    endtask

    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (exec_q.size() == 0 && tx_q.size() == 0 && err_expect == 0) begin
                done = 1'b1;
                break;
            end
            tick(1);
        end
        check({"frame_complete_", name}, 64'(done), 64'd1);
        tick(3);
    endtask

    task automatic send_frame(input bit oper, input logic [15:0] a, input logic [15:0] b,
                              input logic [7:0] fun_b, input int delay, input logic [3:0] flg,
                              input bit inject, input bit hold_busy, input string name);
        exec_t       e;
        logic [15:0] res;
        bit          ok;
        int          k;
        if (oper) begin
            m_a = a;
            m_b = b;
        end
        e.a = m_a;
        e.b = m_b;
        e.fun = fun_b[3:0];
        exec_q.push_back(e);
        ok = (delay >= 1) && (delay <= WAIT_MAX - 1);
        if (ok) begin
            res = alu_calc(m_a, m_b, fun_b[3:0]);
            tx_q.push_back(res[7:0]);
            tx_q.push_back(res[15:8]);
            if (TX_BYTES == 3) tx_q.push_back({4'b0000, flg});
        end else begin
            err_expect++;
        end
        resp_delay = delay;
        resp_flags = flg;
        if (hold_busy) force_busy = 1'b1;
        send_byte(oper ? CMD_OPER : CMD_NOPER);
        if (oper) begin
            send_byte(a[7:0]);
            send_byte(a[15:8]);
            send_byte(b[7:0]);
            send_byte(b[15:8]);
        end
        send_byte(fun_b);
        if (hold_busy) begin
            k = 0;
            while (!TX_D_VLD && k < 200) begin
                tick(1);
                k++;
            end
            check("busy_tx_presented", 64'(TX_D_VLD), 64'd1);
            repeat (30) begin
                rx_inject();
                tick(1);
            end
            RX_D_VLD   = 1'b0;
            force_busy = 1'b0;
        end
        if (inject && ok) begin
            for (int i = 0; i < 400; i++) begin
                if (tx_q.size() == 0) break;
                rx_inject();
                tick(1);
            end
            RX_D_VLD = 1'b0;
        end
        wait_done(name);
    endtask

    initial begin
        int          n0;
        int          e0;
        int          r;
        int          dly;
        logic [7:0]  g;
        RST       = 1'b1;
        RX_D_VLD  = 1'b0;
        RX_P_DATA = '0;
        #2 RST = 1'b0;
        tick(3);
        RST = 1'b1;

        for (int i = 0; i < 20; i++) begin
            check("reset_idle_outputs",
                  64'({ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, ERR}), 64'd0);
            tick(1);
        end

        // Directed: full ADD frame.
        n0 = tx_log.size();
        e0 = en_count;
        send_frame(1'b1, 16'h000F, 16'h0003, 8'h00, 2, 4'b1000, 1'b0, 1'b0, "add");
        check("add_en_pulses", 64'(en_count - e0), 64'd1);
        check("add_a", 64'(ALU_A), 64'h000F);
        check("add_b", 64'(ALU_B), 64'h0003);
        check("add_fun", 64'(ALU_FUN), 64'h0);
        check("add_tx_count", 64'(tx_log.size() - n0), 64'(TX_BYTES));
        if (tx_log.size() - n0 == TX_BYTES) begin
            check("add_tx_lo", 64'(tx_log[n0]), 64'h12);
            check("add_tx_hi", 64'(tx_log[n0 + 1]), 64'h00);
            if (TX_BYTES == 3) check("add_tx_flags", 64'(tx_log[n0 + 2]), 64'h08);
        end

        // Directed: NOPER reuses A/B, MUL.
        n0 = tx_log.size();
        send_frame(1'b0, 16'h0, 16'h0, 8'h02, 4, 4'b0000, 1'b0, 1'b0, "mul");
        check("mul_a_kept", 64'(ALU_A), 64'h000F);
        check("mul_b_kept", 64'(ALU_B), 64'h0003);
        check("mul_fun", 64'(ALU_FUN), 64'h2);
        if (tx_log.size() - n0 == TX_BYTES) begin
            check("mul_tx_lo", 64'(tx_log[n0]), 64'h2D);
            check("mul_tx_hi", 64'(tx_log[n0 + 1]), 64'h00);
        end else begin
            check("mul_tx_count", 64'(tx_log.size() - n0), 64'(TX_BYTES));
        end

        // Directed: timeout, then boundary latencies on either side of WAIT_MAX.
        n0 = tx_log.size();
        send_frame(1'b1, 16'h1234, 16'h5678, 8'h05, 0, 4'h0, 1'b0, 1'b0, "timeout");
        check("timeout_no_tx", 64'(tx_log.size() - n0), 64'd0);
        send_frame(1'b1, 16'h0100, 16'h0023, 8'hF1, WAIT_MAX - 1, 4'h3, 1'b0, 1'b0, "last_ok");
        n0 = tx_log.size();
        send_frame(1'b0, 16'h0, 16'h0, 8'h04, WAIT_MAX, 4'h1, 1'b0, 1'b0, "late");
        check("late_no_tx", 64'(tx_log.size() - n0), 64'd0);
        send_frame(1'b0, 16'h0, 16'h0, 8'h08, 1, 4'h5, 1'b1, 1'b0, "after_late");

        // Directed: TX backpressure with RX noise.
        n0 = tx_log.size();
        send_frame(1'b1, 16'hBEEF, 16'h0101, 8'h09, 3, 4'h6, 1'b1, 1'b1, "busy");
        check("busy_tx_count", 64'(tx_log.size() - n0), 64'(TX_BYTES));

        // Directed: reset while collecting B high byte.
        send_byte(CMD_OPER);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        RST = 1'b0;
        #1;
        check("midreset_outputs",
              64'({ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, ERR}), 64'd0);
        tick(2);
        RST = 1'b1;
        m_a = '0;
        m_b = '0;
        exec_q.delete();
        tx_q.delete();
        err_expect = 0;
        tick(2);
        n0 = tx_log.size();
        send_frame(1'b0, 16'h0, 16'h0, 8'h0E, 3, 4'h0, 1'b0, 1'b0, "post_reset");
        check("post_reset_a", 64'(ALU_A), 64'h0);
        check("post_reset_b", 64'(ALU_B), 64'h0);
        check("post_reset_fun", 64'(ALU_FUN), 64'hE);
        if (tx_log.size() - n0 == TX_BYTES) begin
            check("post_reset_tx_lo", 64'(tx_log[n0]), 64'h00);
            check("post_reset_tx_hi", 64'(tx_log[n0 + 1]), 64'h00);
        end else begin
            check("post_reset_tx_count", 64'(tx_log.size() - n0), 64'(TX_BYTES));
        end

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == CMD_OPER || g == CMD_NOPER) g = 8'h00;
                send_byte(g);
            end
            r = $urandom_range(0, 9);
            dly = (r == 0) ? 0 : (r == 1) ? WAIT_MAX : (r == 2) ? WAIT_MAX - 1 :
                  (r == 3) ? 1 : $urandom_range(1, WAIT_MAX - 1);
            send_frame($urandom_range(0, 2) != 0, 16'($urandom), 16'($urandom), 8'($urandom),
                       dly, 4'($urandom), $urandom_range(0, 1) == 1, 1'b0, "random");
        end

        check("final_exec_q_empty", 64'(exec_q.size()), 64'd0);
        check("final_tx_q_empty", 64'(tx_q.size()), 64'd0);
        check("final_err_pending", 64'(err_expect), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
